// File: rtl/ch0re_alu_arbiter_pkg.sv
// Shared types for the execute-stage ALU and its request arbiter.
package ch0re_types;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [63:0] res;
    logic        zero;
    logic        less;
  } alu_rsp_t;

  localparam int unsigned ALU_ARB_MAX_REQ = 8;

  // Distance of idx from the round-robin pointer, counting upward with wrap.
  function automatic int unsigned rr_dist(input int unsigned idx, input int unsigned ptr,
                                          input int unsigned n);
    return (idx + n - ptr) % n;
  endfunction

endpackage

// File: rtl/ch0re_alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or above the pointer, with wrap.
module ch0re_rr_pick
  import ch0re_types::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned best_d;
  int unsigned ptr_int;

  always_comb begin
    best_d  = N;
    ptr_int = 32'(ptr_i);
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (valid_i[j] && (rr_dist(j, ptr_int, N) < best_d)) begin
        best_d = rr_dist(j, ptr_int, N);
        idx_o  = IW'(j);
        any_o  = 1'b1;
      end
    end
  end

  always_comb begin
    onehot_o = '0;
    for (int unsigned j = 0; j < N; j++) begin
      onehot_o[j] = any_o && (idx_o == IW'(j));
    end
  end

endmodule

// File: rtl/ch0re_alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Optional per-requester accept counters on o_grant_cnt when CH0RE_ALU_ARB_STATS_EN is defined.
module ch0re_alu_arbiter
  import ch0re_types::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  alu_op_e [NUM_REQ-1:0]      i_req_op,
  input  logic [NUM_REQ-1:0][63:0]   i_req_s1,
  input  logic [NUM_REQ-1:0][63:0]   i_req_s2,
  output alu_op_e                    o_alu_op,
  output logic [63:0]                o_alu_s1,
  output logic [63:0]                o_alu_s2,
  input  logic [63:0]                i_alu_res,
  input  logic                       i_alu_zero,
  input  logic                       i_alu_less,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [ID_W-1:0]            o_rsp_id,
  output logic [63:0]                o_rsp_res,
  output logic                       o_rsp_zero,
`ifdef CH0RE_ALU_ARB_STATS_EN
  output logic [NUM_REQ-1:0][31:0]   o_grant_cnt,
`endif
  output logic                       o_rsp_less
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  alu_rsp_t           rsp_q, rsp_d;

  logic [NUM_REQ-1:0] win_onehot;
  logic [ID_W-1:0]    win_idx;
  logic               win_any;
  logic               slot_free;
  logic               grant;

  ch0re_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .valid_i  (i_req_valid),
    .ptr_i    (ptr_q),
    .onehot_o (win_onehot),
    .idx_o    (win_idx),
    .any_o    (win_any)
  );

  // Reset gates the grant so nothing is accepted while the slot is being cleared.
  assign slot_free   = !rsp_valid_q || i_rsp_ready;
  assign grant       = i_rst_n && slot_free && win_any;
  assign o_req_ready = grant ? win_onehot : '0;

  always_comb begin
    o_alu_op = ALU_ADD;
    o_alu_s1 = '0;
    o_alu_s2 = '0;
    if (grant) begin
      o_alu_op = i_req_op[win_idx];
      o_alu_s1 = i_req_s1[win_idx];
      o_alu_s2 = i_req_s2[win_idx];
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_d       = rsp_q;
    if (grant) begin
      ptr_d       = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      rsp_valid_d = 1'b1;
      rsp_id_d    = win_idx;
      rsp_d.res   = i_alu_res;
      rsp_d.zero  = i_alu_zero;
      rsp_d.less  = i_alu_less;
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_q       <= rsp_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_res   = rsp_q.res;
  assign o_rsp_zero  = rsp_q.zero;
  assign o_rsp_less  = rsp_q.less;

`ifdef CH0RE_ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (i_req_valid[k] && o_req_ready[k]) begin
          grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
        end
      end
    end
  end

  assign o_grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_ch0re_alu_arbiter.sv
// Directed self-checking bench for ch0re_alu_arbiter with a two-requester configuration.
module tb_ch0re_alu_arbiter;
  import ch0re_types::*;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  alu_op_e [1:0]        req_op;
  logic [1:0][63:0]     req_s1;
  logic [1:0][63:0]     req_s2;
  alu_op_e              alu_op;
  logic [63:0]          alu_s1;
  logic [63:0]          alu_s2;
  logic [63:0]          alu_res;
  logic                 alu_zero;
  logic                 alu_less;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [0:0]           rsp_id;
  logic [63:0]          rsp_res;
  logic                 rsp_zero;
  logic                 rsp_less;
`ifdef CH0RE_ALU_ARB_STATS_EN
  logic [1:0][31:0]     grant_cnt;
`endif

  int n_cmp;
  int n_err;

  ch0re_alu_arbiter #(.NUM_REQ(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_s1    (req_s1),
    .i_req_s2    (req_s2),
    .o_alu_op    (alu_op),
    .o_alu_s1    (alu_s1),
    .o_alu_s2    (alu_s2),
    .i_alu_res   (alu_res),
    .i_alu_zero  (alu_zero),
    .i_alu_less  (alu_less),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_res   (rsp_res),
    .o_rsp_zero  (rsp_zero),
`ifdef CH0RE_ALU_ARB_STATS_EN
    .o_grant_cnt (grant_cnt),
`endif
    .o_rsp_less  (rsp_less)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared ALU.
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_res = alu_s1 + alu_s2;
      ALU_SUB: alu_res = alu_s1 - alu_s2;
      ALU_SLT: alu_res = {63'd0, $signed(alu_s1) < $signed(alu_s2)};
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == 64'd0);
    alu_less = $signed(alu_s1) < $signed(alu_s2);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rsp_ready = 1'b1;
    req_op[0] = ALU_ADD; req_s1[0] = 64'd1; req_s2[0] = 64'd2;
    req_valid = 2'b01;
    @(posedge clk); #1;
    @(negedge clk);
    req_op[1] = ALU_ADD; req_s1[1] = 64'd10; req_s2[1] = 64'd20;
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    n_cmp++; if (rsp_res !== 64'd0) begin n_err++; $display("FAIL reset_rsp_res got %h exp 0", rsp_res); end
    n_cmp++; if (rsp_id !== 1'b0 || rsp_zero !== 1'b0 || rsp_less !== 1'b0) begin
      n_err++; $display("FAIL reset_fields got id=%b z=%b l=%b exp 0/0/0", rsp_id, rsp_zero, rsp_less);
    end
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_hold_valid got %b exp 0", rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL reset_first_grant got %b exp 01", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 64'd3) begin
      n_err++; $display("FAIL reset_first_rsp got v=%b id=%b res=%0d exp 1/0/3", rsp_valid, rsp_id, rsp_res);
    end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    do_reset();
    req_op[0] = ALU_ADD; req_s1[0] = 64'd5; req_s2[0] = 64'd7;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got %b exp 01", req_ready); end
    n_cmp++; if (alu_op !== ALU_ADD || alu_s1 !== 64'd5 || alu_s2 !== 64'd7) begin
      n_err++; $display("FAIL single_alu_lines got op=%0d s1=%0d s2=%0d exp 0/5/7", alu_op, alu_s1, alu_s2);
    end
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
      n_err++; $display("FAIL single_rsp got v=%b id=%b exp 1/0", rsp_valid, rsp_id);
    end
    n_cmp++; if (rsp_res !== 64'd12 || rsp_zero !== 1'b0 || rsp_less !== 1'b1) begin
      n_err++; $display("FAIL single_res got res=%0d z=%b l=%b exp 12/0/1", rsp_res, rsp_zero, rsp_less);
    end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    n_cmp++; if (req_ready !== 2'b00 || alu_s1 !== 64'd0 || alu_op !== ALU_ADD) begin
      n_err++; $display("FAIL idle_lines got rdy=%b op=%0d s1=%0d exp 00/0/0", req_ready, alu_op, alu_s1);
    end
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b exp 0", rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    do_reset();
    req_op[0] = ALU_SUB; req_s1[0] = 64'd3; req_s2[0] = 64'd3;
    req_op[1] = ALU_SLT; req_s1[1] = 64'hFFFF_FFFF_FFFF_FFFF; req_s2[1] = 64'd1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL contend_ready[%0d] got %b exp %b", i, req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      @(posedge clk); #1;
      if (i % 2 == 0) begin
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 64'd0 || rsp_zero !== 1'b1 || rsp_less !== 1'b0) begin
          n_err++; $display("FAIL contend_rsp[%0d] got v=%b id=%b res=%0d z=%b l=%b exp 1/0/0/1/0", i, rsp_valid, rsp_id, rsp_res, rsp_zero, rsp_less);
        end
      end else begin
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_res !== 64'd1 || rsp_zero !== 1'b0 || rsp_less !== 1'b1) begin
          n_err++; $display("FAIL contend_rsp[%0d] got v=%b id=%b res=%0d z=%b l=%b exp 1/1/1/0/1", i, rsp_valid, rsp_id, rsp_res, rsp_zero, rsp_less);
        end
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_op[0] = ALU_ADD; req_s1[0] = 64'd5; req_s2[0] = 64'd7;
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_first_ready got %b exp 01", req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    req_op[1] = ALU_SLT; req_s1[1] = 64'hFFFF_FFFF_FFFF_FFFF; req_s2[1] = 64'd1;
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (req_ready !== 2'b00 || alu_op !== ALU_ADD || alu_s1 !== 64'd0) begin
        n_err++; $display("FAIL bp_stall[%0d] got rdy=%b op=%0d s1=%h exp 00/0/0", i, req_ready, alu_op, alu_s1);
      end
      @(posedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 64'd12) begin
        n_err++; $display("FAIL bp_hold[%0d] got v=%b id=%b res=%0d exp 1/0/12", i, rsp_valid, rsp_id, rsp_res);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_release_ready got %b exp 10", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_res !== 64'd1) begin
      n_err++; $display("FAIL bp_release_rsp got v=%b id=%b res=%0d exp 1/1/1", rsp_valid, rsp_id, rsp_res);
    end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic test_drain_accept();
    do_reset();
    req_op[0] = ALU_SUB; req_s1[0] = 64'd9; req_s2[0] = 64'd4;
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_res !== 64'd5 || rsp_id !== 1'b0) begin
      n_err++; $display("FAIL da_fill got v=%b res=%0d id=%b exp 1/5/0", rsp_valid, rsp_res, rsp_id);
    end
    @(negedge clk);
    req_op[1] = ALU_ADD; req_s1[1] = 64'd1; req_s2[1] = 64'd1;
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL da_ready got %b exp 10", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_res !== 64'd2) begin
      n_err++; $display("FAIL da_replace got v=%b id=%b res=%0d exp 1/1/2", rsp_valid, rsp_id, rsp_res);
    end
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL da_drain got %b exp 0", rsp_valid); end
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL ptr_wrap got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

`ifdef CH0RE_ALU_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    n_cmp++; if (grant_cnt !== 64'd0) begin n_err++; $display("FAIL stats_reset got %h exp 0", grant_cnt); end
    req_op[0] = ALU_ADD; req_op[1] = ALU_ADD;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    req_valid = 2'b00;
    #1;
    n_cmp++; if (grant_cnt[0] !== 32'd5 || grant_cnt[1] !== 32'd5) begin
      n_err++; $display("FAIL stats_count got %0d/%0d exp 5/5", grant_cnt[0], grant_cnt[1]);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req_op    = {ALU_ADD, ALU_ADD};
    req_s1    = '0;
    req_s2    = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_drain_accept();
`ifdef CH0RE_ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish before 100000");
    $fatal(1);
  end

endmodule
